// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory path: access sizes (also used by the core LSU),
// the arbiter FSM states, and the alignment helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        return (size == SZ_X) ||
               ((size == SZ_H) && off[0]) ||
               ((size == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for 32-bit memory words: load extract/extend and sub-word store merge.
// Purely combinational so the core's load path can reuse it.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rd_word[{off, 3'b000} +: 8];
        half_v     = rd_word[{off[1], 4'b0000} +: 16];
        load_data  = rd_word;
        store_word = wdata;
        case (size)
            SZ_B: begin
                load_data  = {{24{~is_unsigned & byte_v[7]}}, byte_v};
                store_word = rd_word;
                store_word[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data  = {{16{~is_unsigned & half_v[15]}}, half_v};
                store_word = rd_word;
                store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory; sub-word stores
// are a single-cycle read-modify-write through the combinational read port.
//   state     | meaning
//   ST_IDLE   | ready offered to the round-robin winner
//   ST_ACCESS | memory addressed, write or load capture
//   ST_RESP   | one-cycle response pulse to the owner
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [3:0]        req_size,
    input  logic [1:0]        req_unsigned,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic [1:0]        resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    size_e       size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        grant;
    logic        accept;
    logic        acc_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // On a tie the port not served last wins.
    always_comb begin
        grant   = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        accept  = (state_q == ST_IDLE) && (req_valid != 2'b00);
        acc_err = misaligned(size_q, addr_q[1:0]) || (addr_q[31:ADDR_W+2] != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    dmem_lane_align u_lane_align (
        .off         (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rd_word     (mem_rd),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        if (accept) begin
            last_grant_d = grant;
            owner_d      = grant;
            we_d         = req_we[grant];
            size_d       = size_e'(req_size[{grant, 1'b0} +: 2]);
            uns_d        = req_unsigned[grant];
            addr_d       = req_addr[{grant, 5'b00000} +: 32];
            wdata_d      = req_wdata[{grant, 5'b00000} +: 32];
        end
        if (state_q == ST_ACCESS) begin
            err_d   = acc_err;
            rdata_d = (acc_err || we_q) ? '0 : load_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Everything is gated by RST so a reset in ACCESS cannot write and a reset in RESP drops the pulse.
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wd     = '0;
        if (!RST) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) req_ready = grant ? 2'b10 : 2'b01;
                end
                ST_ACCESS: begin
                    mem_addr = addr_q[ADDR_W+1:2];
                    if (we_q && !acc_err) begin
                        mem_we = 1'b1;
                        mem_wd = store_word;
                    end
                end
                ST_RESP: begin
                    resp_valid = owner_q ? 2'b10 : 2'b01;
                    resp_rdata = rdata_q;
                    resp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-port request queues feed a driver, expected
// responses and memory writes are queued at issue time and popped by two monitors.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int ADDR_W = 5;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0]        req_we = '0;
    logic [3:0]        req_size = '0;
    logic [1:0]        req_unsigned = '0;
    logic [63:0]       req_addr = '0;
    logic [63:0]       req_wdata = '0;
    logic [1:0]        resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    logic [31:0] mem [0:31] = '{default: 32'h0};

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    always #5 CLK = ~CLK;

    assign mem_rd = mem[mem_addr];
    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wd;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    req_t  pq0[$];
    req_t  pq1[$];
    resp_t exp_q[$];
    wr_t   wr_q[$];
    int    acc_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int acc_cnt = 0;
    bit jit1 = 1'b0;

    req_t  drv_r;
    resp_t mon_e;
    wr_t   mon_w;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input bit exp_wr, input logic [31:0] exp_wd, input bit want_resp);
        req_t  r;
        resp_t e;
        wr_t   w;
        r.we = we; r.size = sz; r.uns = uns; r.addr = a; r.wdata = d;
        if (p == 0) pq0.push_back(r);
        else        pq1.push_back(r);
        if (want_resp) begin
            e.port = p; e.rdata = exp_rd; e.err = exp_err;
            exp_q.push_back(e);
            if (exp_wr) begin
                w.addr = a[ADDR_W+1:2]; w.data = exp_wd;
                wr_q.push_back(w);
            end
        end
    endtask

    task automatic st(input int p, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] merged);
        issue(p, 1'b1, sz, 1'b0, a, d, 32'h0, 1'b0, 1'b1, merged, 1'b1);
    endtask

    task automatic ld(input int p, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] exp);
        issue(p, 1'b0, sz, u, a, 32'h0, exp, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic err_req(input int p, input logic we, input logic [1:0] sz, input logic [31:0] a);
        issue(p, we, sz, 1'b0, a, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic drain();
        int pending;
        pending = 1;
        for (int i = 0; i < 300 && pending != 0; i++) begin
            @(posedge CLK);
            pending = pq0.size() + pq1.size() + exp_q.size() + wr_q.size();
        end
        chk("drain_pending", 32'(pending), 32'h0);
        repeat (2) @(posedge CLK);
    endtask

    task automatic wait_acc();
        int start;
        bit seen;
        start = acc_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge CLK);
            if (acc_cnt != start) seen = 1'b1;
        end
        chk("accept_seen", 32'(seen), 32'h1);
    endtask

    // Driver: handshake sampled mid-cycle, new payload applied just after the edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (req_valid[0] && req_ready[0]) begin
                    acc_q.push_back(cyc); last_acc = cyc; acc_cnt++;
                    drv_r = pq0.pop_front();
                end
                if (req_valid[1] && req_ready[1]) begin
                    acc_q.push_back(cyc); last_acc = cyc; acc_cnt++;
                    drv_r = pq1.pop_front();
                end
            end
            @(posedge CLK);
            #1;
            req_valid[0] = (pq0.size() != 0);
            if (pq0.size() != 0) begin
                drv_r = pq0[0];
                req_we[0] = drv_r.we; req_size[1:0] = drv_r.size; req_unsigned[0] = drv_r.uns;
                req_addr[31:0] = drv_r.addr; req_wdata[31:0] = drv_r.wdata;
            end
            req_valid[1] = (pq1.size() != 0);
            if (pq1.size() != 0) begin
                drv_r = pq1[0];
                req_we[1] = drv_r.we; req_size[3:2] = drv_r.size; req_unsigned[1] = drv_r.uns;
                req_addr[63:32] = drv_r.addr; req_wdata[63:32] = drv_r.wdata;
            end
            #1;
            if (jit1 && req_valid[1] && !req_ready[1]) begin
                req_addr[63:32]  = $urandom & 32'h0000_007C;
                req_wdata[63:32] = $urandom;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && resp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL resp_unexpected: resp_valid=%b rdata=%h, nothing expected", resp_valid, resp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_port", 32'(resp_valid), (mon_e.port == 1) ? 32'h2 : 32'h1);
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_err", 32'(resp_err), 32'(mon_e.err));
                if (acc_q.size() != 0) chk("resp_latency", 32'(cyc - acc_q.pop_front()), 32'h2);
            end
        end
    end

    always @(negedge CLK) begin
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL write_unexpected: mem_addr=%0d mem_wd=%h, no write expected", mem_addr, mem_wd);
            end else begin
                mon_w = wr_q.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(mon_w.addr));
                chk("write_data", mem_wd, mon_w.data);
                chk("write_latency", 32'(cyc - last_acc), 32'h1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: a pending request must not see ready while RST is high.
        ld(0, SZ_W, 1'b0, 32'h0000_0004, 32'h0);
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_valid_driven", 32'(req_valid), 32'h1);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        @(posedge CLK);
        #1 RST = 1'b0;
        drain();

        // Word store then load; seed word 2 for the reset test.
        st(0, SZ_W, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        ld(0, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        st(0, SZ_W, 32'h0000_0008, 32'hCAFE_0002, 32'hCAFE_0002);
        drain();

        // Byte and half lanes; upper store data bits must be ignored.
        st(0, SZ_W, 32'h0000_0000, 32'h1122_3344, 32'h1122_3344);
        st(0, SZ_B, 32'h0000_0002, 32'hFFFF_FFAA, 32'h11AA_3344);
        ld(0, SZ_B, 1'b0, 32'h0000_0002, 32'hFFFF_FFAA);
        ld(0, SZ_B, 1'b1, 32'h0000_0002, 32'h0000_00AA);
        st(0, SZ_H, 32'h0000_0000, 32'h1234_8001, 32'h11AA_8001);
        ld(0, SZ_H, 1'b0, 32'h0000_0000, 32'hFFFF_8001);
        ld(0, SZ_H, 1'b1, 32'h0000_0002, 32'h0000_11AA);
        drain();

        // Serve port 1 alone so port 0 wins the first tie below.
        ld(1, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        drain();

        // Contention: both ports hold valid, grants alternate 0,1,0,1,0,1.
        ld(0, SZ_W, 1'b0, 32'h0000_0000, 32'h11AA_8001);
        ld(1, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        ld(0, SZ_B, 1'b1, 32'h0000_0001, 32'h0000_0080);
        ld(1, SZ_B, 1'b0, 32'h0000_0013, 32'hFFFF_FFDE);
        ld(0, SZ_H, 1'b0, 32'h0000_0002, 32'h0000_11AA);
        ld(1, SZ_H, 1'b1, 32'h0000_0012, 32'h0000_DEAD);
        drain();

        // Errors: rdata 0, err 1, no write; last in-range word is fine.
        err_req(0, 1'b0, SZ_W, 32'h0000_0002);
        err_req(0, 1'b0, SZ_H, 32'h0000_0001);
        err_req(0, 1'b0, 2'b11, 32'h0000_0000);
        err_req(0, 1'b1, SZ_W, 32'h0000_0080);
        err_req(0, 1'b1, SZ_H, 32'h0000_0003);
        ld(0, SZ_W, 1'b0, 32'h0000_007C, 32'h0);
        drain();

        // Hold: port 1 payload scrambles while not ready; accept edge payload must be used.
        st(0, SZ_W, 32'h0000_0014, 32'h0BAD_F00D, 32'h0BAD_F00D);
        wait_acc();
        jit1 = 1'b1;
        st(1, SZ_W, 32'h0000_0018, 32'h600D_CAFE, 32'h600D_CAFE);
        ld(0, SZ_W, 1'b0, 32'h0000_0014, 32'h0BAD_F00D);
        drain();
        jit1 = 1'b0;
        ld(1, SZ_W, 1'b0, 32'h0000_0018, 32'h600D_CAFE);
        drain();

        // Reset during ACCESS of a store: no write, no response, port 0 wins the next tie.
        issue(0, 1'b1, SZ_W, 1'b0, 32'h0000_0008, 32'h0000_0005, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_acc();
        #1 RST = 1'b1;
        #1;
        chk("rst_access_mem_we", 32'(mem_we), 32'h0);
        ld(0, SZ_W, 1'b0, 32'h0000_0008, 32'hCAFE_0002);
        ld(1, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        acc_q.delete();
        drain();
        chk("mem_word2_kept", mem[2], 32'hCAFE_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
